// File: rtl/ds1302_pkg.sv
// Shared state encoding, register map and framing constants for the DS1302 transfer engine.
package ds1302_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCmd,
        StData,
        StHold,
        StInactive
    } state_t;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_WDATA  = 2'd1;
    localparam logic [1:0] ADDR_RDATA  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;

    localparam int unsigned HALVES_PER_BYTE = 16;

endpackage

// File: rtl/ds1302_tick.sv
// Half-period strobe for the DS1302 engine: one-cycle pulse every CLK_DIV enabled cycles.
module ds1302_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic csi_clk,
    input  logic csi_reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] count_q;

    always_ff @(posedge csi_clk) begin
        if (csi_reset || clear) begin
            count_q <= RELOAD;
        end else if (enable) begin
            count_q <= (count_q == 16'd0) ? RELOAD : count_q - 16'd1;
        end
    end

    assign tick = enable && (count_q == 16'd0);

endmodule

// File: rtl/ds1302_xfer.sv
// DS1302 3-wire transaction engine behind an Avalon-MM slave: shifts a command byte out,
// then either writes a data byte or captures one from the device.
module ds1302_xfer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       csi_clk,
    input  logic       csi_reset,
    input  logic [1:0] avs_s1_address,
    input  logic       avs_s1_read,
    input  logic       avs_s1_write,
    input  logic [7:0] avs_s1_writedata,
    output logic [7:0] avs_s1_readdata,
    output logic       coe_clk,
    output logic       coe_reset,
    inout  wire        coe_io
);
    import ds1302_pkg::*;

    state_t     state_q;
    logic [3:0] half_q;
    logic [7:0] cmd_q;
    logic [7:0] wdata_q;
    logic [7:0] data_q;
    logic [7:0] rdata_q;
    logic       done_q;
    logic       sclk_q;
    logic       ce_q;
    logic       io_oe_q;
    logic       io_out_q;

    logic       busy;
    logic       accept;
    logic       tick;
    logic       last_half;
    logic [2:0] cur_bit;
    logic [2:0] next_bit;
    logic [7:0] status;

    assign busy      = (state_q != StIdle);
    assign accept    = avs_s1_write && (avs_s1_address == ADDR_CMD) && !busy;
    assign last_half = (half_q == 4'(HALVES_PER_BYTE - 1));
    assign cur_bit   = half_q[3:1];
    assign next_bit  = half_q[3:1] + 3'd1;

    always_comb begin
        status              = 8'h00;
        status[STATUS_BUSY] = busy;
        status[STATUS_DONE] = done_q;
    end

    ds1302_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .csi_clk   (csi_clk),
        .csi_reset (csi_reset),
        .clear     (accept),
        .enable    (busy),
        .tick      (tick)
    );

    assign coe_clk   = sclk_q;
    assign coe_reset = ce_q;
    assign coe_io    = io_oe_q ? io_out_q : 1'bz;

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            state_q         <= StIdle;
            half_q          <= 4'd0;
            cmd_q           <= 8'h00;
            wdata_q         <= 8'h00;
            data_q          <= 8'h00;
            rdata_q         <= 8'h00;
            done_q          <= 1'b0;
            sclk_q          <= 1'b0;
            ce_q            <= 1'b0;
            io_oe_q         <= 1'b0;
            io_out_q        <= 1'b0;
            avs_s1_readdata <= 8'h00;
        end else begin
            if (avs_s1_read) begin
                unique case (avs_s1_address)
                    ADDR_CMD:    avs_s1_readdata <= cmd_q;
                    ADDR_WDATA:  avs_s1_readdata <= wdata_q;
                    ADDR_RDATA:  avs_s1_readdata <= rdata_q;
                    ADDR_STATUS: avs_s1_readdata <= status;
                endcase
            end

            if (avs_s1_write && (avs_s1_address == ADDR_WDATA)) begin
                wdata_q <= avs_s1_writedata;
            end
            if (avs_s1_write && (avs_s1_address == ADDR_STATUS) &&
                avs_s1_writedata[STATUS_DONE]) begin
                done_q <= 1'b0;
            end

            if (accept) begin
                // Snapshot WDATA so later writes only affect the next transfer.
                cmd_q    <= avs_s1_writedata;
                data_q   <= wdata_q;
                done_q   <= 1'b0;
                state_q  <= StSetup;
                half_q   <= 4'd0;
                ce_q     <= 1'b1;
                sclk_q   <= 1'b0;
                io_oe_q  <= 1'b1;
                io_out_q <= avs_s1_writedata[0];
            end else if (tick) begin
                unique case (state_q)
                    StSetup: begin
                        state_q <= StCmd;
                        half_q  <= 4'd0;
                    end
                    StCmd: begin
                        half_q <= half_q + 4'd1;
                        if (!half_q[0]) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (last_half) begin
                                state_q  <= StData;
                                io_oe_q  <= !cmd_q[0];
                                io_out_q <= data_q[0];
                            end else begin
                                io_out_q <= cmd_q[next_bit];
                            end
                        end
                    end
                    StData: begin
                        half_q <= half_q + 4'd1;
                        if (!half_q[0]) begin
                            sclk_q <= 1'b1;
                            // Last cycle of the low half: the device has settled its output.
                            if (cmd_q[0]) begin
                                data_q[cur_bit] <= coe_io;
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            if (last_half) begin
                                state_q <= StHold;
                                io_oe_q <= 1'b0;
                                if (cmd_q[0]) begin
                                    rdata_q <= data_q;
                                end
                            end else if (!cmd_q[0]) begin
                                io_out_q <= data_q[next_bit];
                            end
                        end
                    end
                    StHold: begin
                        state_q <= StInactive;
                        half_q  <= 4'd0;
                        ce_q    <= 1'b0;
                    end
                    StInactive: begin
                        if (half_q[0]) begin
                            state_q <= StIdle;
                            half_q  <= 4'd0;
                            done_q  <= 1'b1;
                        end else begin
                            half_q <= 4'd1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
